// File: rtl/barrier_scroller.sv
// Scrolling pipe barriers for the green plane of the 8x8 matrix.
// A pipe or an empty column enters at column 0 on each scroll step.
module barrier_scroller #(
    parameter int TICK_CYCLES = 25_000_000,
    parameter int GAP_HEIGHT  = 3,
    parameter int SPACING     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            dead,
    output logic [7:0][7:0] green_array,
    output logic            pipe_passed
);

    localparam int TW = $clog2(TICK_CYCLES);
    localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPACING - 1);
    localparam logic [2:0]    MAX_TOP    = 3'(8 - GAP_HEIGHT);
    localparam logic [7:0]    GAP_MASK   = 8'((1 << GAP_HEIGHT) - 1);

    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [7:0][7:0] green_q, green_d;
    logic            pipe_passed_q, pipe_passed_d;

    logic       run;
    logic       step;
    logic       spawn_now;
    logic       col6_lit;
    logic [2:0] raw;
    logic [2:0] gap_top;
    logic [7:0] pipe_col;
    logic [7:0] new_col;

    always_comb begin
        run       = enable & ~dead;
        step      = run && (tick_cnt_q == TICK_LAST);
        spawn_now = (spawn_cnt_q == SPAWN_LAST);
        raw       = lfsr_q[2:0];
        // Fold out-of-range LFSR values back into the legal gap positions.
        gap_top   = (raw <= MAX_TOP) ? raw : (raw - (MAX_TOP + 3'd1));
        pipe_col  = ~(GAP_MASK << gap_top);
        new_col   = spawn_now ? pipe_col : 8'h00;

        col6_lit = 1'b0;
        for (int r = 0; r < 8; r++) begin
            col6_lit = col6_lit | green_q[r][6];
        end

        tick_cnt_d    = tick_cnt_q;
        spawn_cnt_d   = spawn_cnt_q;
        lfsr_d        = lfsr_q;
        green_d       = green_q;
        pipe_passed_d = 1'b0;

        if (run) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end

        if (step) begin
            pipe_passed_d = col6_lit;
            for (int r = 0; r < 8; r++) begin
                green_d[r] = {green_q[r][6:0], new_col[r]};
            end
            if (spawn_now) begin
                spawn_cnt_d = '0;
                lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end else begin
                spawn_cnt_d = spawn_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q    <= '0;
            spawn_cnt_q   <= SPAWN_LAST;
            lfsr_q        <= 8'h01;
            green_q       <= '0;
            pipe_passed_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            spawn_cnt_q   <= spawn_cnt_d;
            lfsr_q        <= lfsr_d;
            green_q       <= green_d;
            pipe_passed_q <= pipe_passed_d;
        end
    end

    assign green_array = green_q;
    assign pipe_passed = pipe_passed_q;

endmodule

// File: doc/barrier_scroller.md
# barrier_scroller

Generates and scrolls the pipe barriers shown in the green plane of the 8x8 LED matrix. It drives `green_array`, the same array that the collision check compares against the bird's red plane. Each scroll step shifts every column one position toward column 7 and inserts either a new pipe or an empty column at column 0. Scrolling freezes when `dead` is high. A pulse is emitted each time a pipe clears the bird column (column 6), and the game's score counter consumes it.

## Interface
- `TICK_CYCLES`, default 25_000_000: clock cycles per scroll step; legal range ≥ 2.
- `GAP_HEIGHT`, default 3: number of unlit rows forming a pipe's opening; legal range 1..5.
- `SPACING`, default 4: columns between consecutive pipes, counted as step count between spawns; legal range ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`; low means reset.
- `enable`  in  1  game running; when low, all state holds.
- `dead`  in  1  collision flag from the collision check; when high, all scrolling state holds.
- `green_array`  out  [7:0][7:0]  barrier plane, indexed `[row][col]`; 1 means LED lit.
- `pipe_passed`  out  1  one-cycle pulse when a pipe column leaves column 6 while `dead` is low.

## Operation
- `run` = `enable & ~dead`.
- **Tick counter** `tick_cnt` (width clog2(TICK_CYCLES)):
  - When `run`, it counts 0..TICK_CYCLES-1 and wraps to 0.
  - When `run` is low, it holds.
  - `step` = `run & (tick_cnt == TICK_CYCLES-1)`.
- **Spawn counter** `spawn_cnt` runs 0..SPACING-1. It changes only on `step`:
  - If `spawn_cnt == SPACING-1`: insert a pipe and set `spawn_cnt` to 0.
  - Otherwise: insert an empty column and increment `spawn_cnt`.
  - Reset value is SPACING-1, so the first step spawns a pipe.
- **Shift on `step`**:
  - `green_array[r][c+1] <= green_array[r][c]` for c = 0..6, all rows.
  - The old column 7 is discarded.
  - Column 0 receives the inserted column.
- **Gap position**:
  - MAX_TOP = 8 - GAP_HEIGHT.
  - `raw` = `lfsr[2:0]`.
  - `gap_top` = `raw` if `raw` ≤ MAX_TOP, else `raw` - (MAX_TOP+1).
  - Pipe column: row r is lit unless `gap_top` ≤ r ≤ `gap_top`+GAP_HEIGHT-1.
- **LFSR**: 8-bit Fibonacci, seed 8'h01.
  - Next value is `{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - It advances only on a step that spawns a pipe, after its current value has been used for that pipe.
  - It never reaches 0.
- **`pipe_passed`**: registered. On `step`, it is set to 1 if the pre-step column 6 is nonzero. It is 0 on every other cycle.
- **`dead` behaviour**: `dead` blocks `step`, so no pulse occurs while dead. The array freezes with the collision state visible.
- `enable` low and `dead` high have identical hold behaviour. Neither clears state; only `reset` clears.

## Timing
- **Reset values** (after the `clk` edge where `reset` = 0):
  - `green_array` = all 0.
  - `pipe_passed` = 0.
  - `tick_cnt` = 0.
  - `spawn_cnt` = SPACING-1.
  - `lfsr` = 8'h01.
- Reset overrides `enable`, `dead` and an in-progress step on the same edge.
- **First update**: with `run` high continuously from the first cycle after reset release, the first array update is on the TICK_CYCLES-th rising edge after release. Later updates occur every TICK_CYCLES edges.
- **Update edge**: the `green_array` update, the `pipe_passed` assertion, the LFSR advance and the `spawn_cnt` update all occur on the same edge, the one where `step` is high.
- **Stall**: dropping `run` for k cycles delays the next step by exactly k cycles. The partial tick count is preserved.
- **Combinational loop**: `dead` arrives combinationally from the current `green_array`. There is no combinational path from `dead` to `green_array` or `pipe_passed`.
- **Wrap-around**: a pipe in column 7 disappears on the next step; no residue remains.
- **Simultaneous events**: `dead` rising in the same cycle as the terminal tick suppresses that step.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles with `enable`=1 -> `green_array`=0 and `pipe_passed`=0 on every cycle. Release; with TICK_CYCLES=4, no change until the 4th edge.
- **First pipe**: use GAP_HEIGHT=3, SPACING=4, TICK_CYCLES=4, `dead`=0 and run 1 step.
  - Required: column 0 has rows 0,4,5,6,7 lit and rows 1-3 clear (`gap_top`=1 from LFSR 8'h01).
  - Required: all other columns are 0.
- **Spacing and second gap**: run 4 more steps.
  - Required: first pipe in column 4; columns 1-3 empty.
  - Required: new pipe in column 0 with rows 2-4 clear (LFSR 8'h02).
- **Pass pulse**: continue until the first pipe moves from column 6 to column 7 -> `pipe_passed`=1 for exactly that one cycle.
- **Freeze**: assert `dead`=1 for 10 cycles mid-tick, then release.
  - Required: array and counters unchanged during the freeze.
  - Required: the next step is delayed by exactly 10 cycles; no pulse occurs during the freeze.
- **Gap fold**: force `lfsr[2:0]`=7 with GAP_HEIGHT=3 -> `gap_top`=1. Also sweep GAP_HEIGHT=5 (MAX_TOP=3), where raw 4..7 maps to 0..3.
